// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter and clear sequencer owning the single write port of rf.
// Latency: a request accepted in cycle N is on the rf port in N+1; clear writes DEPTH zeros back to back.
// Backpressure: ready is combinational, at most one-hot, and held low during clear, a clear request or reset.
module rf_write_arbiter #(
  parameter int  BW    = 8,
  parameter int  DEPTH = 256,
  parameter int  NREQ  = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int IW    = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid_i,
  input  logic [NREQ-1:0][AW-1:0] req_addr_i,
  input  logic [NREQ-1:0][BW-1:0] req_data_i,
  output logic [NREQ-1:0]         req_ready_o,
  input  logic                    clear_i,
  output logic                    busy_o,
  output logic [IW-1:0]           grant_id_o,
  output logic [BW-1:0]           rf_data_o,
  output logic [AW-1:0]           rf_write_addr_o,
  output logic                    rf_write_en_n_o,
  output logic                    rf_chip_en_o
);

  typedef enum logic {RUN = 1'b0, CLEAR = 1'b1} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] ptr;
  logic [AW-1:0] cnt;
  logic          win_vld;
  logic [IW-1:0] win_id;
  logic [IW-1:0] idx;
  logic          grant;
  logic          cnt_last;

  assign cnt_last = (cnt == AW'(DEPTH - 1));
  assign grant    = (state == RUN) && !clear_i && win_vld && !rst;

  // First valid requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IW'((int'(ptr) + k) % NREQ);
      if (!win_vld && req_valid_i[idx]) begin
        win_vld = 1'b1;
        win_id  = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (clear_i)  state_nxt = CLEAR;
      CLEAR:   if (cnt_last) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    req_ready_o = '0;
    busy_o      = (state == CLEAR);
    if (grant) req_ready_o[win_id] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr             <= '0;
      cnt             <= '0;
      grant_id_o      <= '0;
      rf_data_o       <= '0;
      rf_write_addr_o <= '0;
      rf_write_en_n_o <= 1'b1;
      rf_chip_en_o    <= 1'b0;
    end else begin
      rf_chip_en_o    <= 1'b1;
      rf_write_en_n_o <= 1'b1;
      if (state == CLEAR) begin
        rf_write_addr_o <= cnt;
        rf_data_o       <= '0;
        rf_write_en_n_o <= 1'b0;
        cnt             <= cnt_last ? '0 : cnt + AW'(1);
      end else if (clear_i) begin
        cnt <= '0;
      end else if (grant) begin
        rf_write_addr_o <= req_addr_i[win_id];
        rf_data_o       <= req_data_i[win_id];
        grant_id_o      <= win_id;
        rf_write_en_n_o <= 1'b0;
        ptr             <= (win_id == IW'(NREQ - 1)) ? '0 : win_id + IW'(1);
      end
    end
  end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Round-robin arbiter and sequencer for the single write port of `rf`. It accepts write requests from `NREQ` independent requesters over valid/ready handshakes and forwards exactly one write per cycle to the register file through registered outputs. It also provides a clear sequence that writes zero to every address, one address per cycle, without pulsing the register file's reset. It sits directly in front of `rf` and owns its `data_in`, `write_addr`, `write_en_n` and `chip_en` inputs; read ports are untouched.

## Interface
- `BW`, 8, data width; must equal `rf` `BW`
- `DEPTH`, 256, register count; must equal `rf` `DEPTH`; `AW = $clog2(DEPTH)`
- `NREQ`, 4, number of requesters, ≥2; `IW = $clog2(NREQ)`

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `req_valid_i`  in  NREQ  per-requester write request
- `req_addr_i`  in  NREQ×AW  per-requester write address
- `req_data_i`  in  NREQ×BW  per-requester write data, signed
- `req_ready_o`  out  NREQ  per-requester accept; combinational, at most one bit high
- `clear_i`  in  1  single-cycle request to zero all registers
- `busy_o`  out  1  high while the clear sequence runs
- `grant_id_o`  out  IW  requester whose write is currently on the rf port
- `rf_data_o`  out  BW  to `rf.data_in`
- `rf_write_addr_o`  out  AW  to `rf.write_addr`
- `rf_write_en_n_o`  out  1  to `rf.write_en_n`, active-low
- `rf_chip_en_o`  out  1  to `rf.chip_en`

## Operation
- State machine with two states: RUN (reset state) and CLEAR.
- Round-robin pointer `ptr` (IW bits), reset 0.
- RUN arbitration, combinational, evaluated every cycle:
  - Scan requesters `ptr`, `ptr+1`, … mod NREQ.
  - The first requester with valid high gets ready high.
  - All ready bits are 0 when `clear_i`=1 or the state is CLEAR.
- Accept means `req_valid_i[i] & req_ready_o[i]` in cycle N. At the edge ending cycle N:
  - `rf_write_addr_o` ← `req_addr_i[i]`, `rf_data_o` ← `req_data_i[i]`, `grant_id_o` ← i, `rf_write_en_n_o` ← 0.
  - `ptr` ← (i+1) mod NREQ; wraps from NREQ-1 to 0.
- No accept in a RUN cycle: `rf_write_en_n_o` ← 1 and `ptr` holds. Address, data and `grant_id_o` hold their last values.
- Requesters must hold valid, addr and data stable until ready. The arbiter never drops an accepted request.
- `clear_i`=1 in RUN:
  - Next state is CLEAR and the address counter `cnt` ← 0.
  - `clear_i` has priority: no request is accepted in that cycle.
- In CLEAR, each cycle loads `rf_write_addr_o` ← `cnt`, `rf_data_o` ← 0, `rf_write_en_n_o` ← 0, then `cnt` ← `cnt`+1.
- When `cnt`=DEPTH-1 is loaded, next state is RUN.
- `clear_i` during CLEAR is ignored and not queued.
- `ptr` and `grant_id_o` are unchanged by a clear.
- `busy_o` = (state == CLEAR).
- `rf_chip_en_o` is registered: 0 in reset, 1 from the first clock edge after `rst` deasserts, then stays 1.
- Reset mid-clear aborts the sequence immediately. No further clear writes occur, state is RUN and `cnt` is 0.

## Timing
- Reset values:
  - `rf_write_en_n_o`=1, `rf_chip_en_o`=0, `rf_data_o`=0, `rf_write_addr_o`=0.
  - `grant_id_o`=0, `busy_o`=0, `req_ready_o`=0.
  - `ptr`=0, `cnt`=0.
- Write latency: accept in cycle N drives the rf port during cycle N+1. `rf` captures the write at the edge ending N+1.
- Throughput: one accepted write per cycle, sustained, in RUN.
- `req_ready_o` depends on current `req_valid_i`, `clear_i`, `ptr` and state. Ready has no dependency on itself, so there is no loop.
- Clear sequence, with `clear_i` high in cycle N:
  - CLEAR occupies cycles N+1 … N+DEPTH.
  - Zero writes appear on the port in cycles N+2 … N+DEPTH+1, addresses 0 … DEPTH-1 in order.
  - RUN resumes, and ready may assert, in cycle N+DEPTH+1.
  - The first request accepted after the clear writes in cycle N+DEPTH+2, so it never collides with a clear write.
- Same-address back-to-back writes are legal; the later one wins in `rf`.

## Test plan
- Reset then idle:
  - Stimulus: assert `rst` asynchronously mid-cycle.
  - Required response: all outputs at their reset values immediately, with no clock edge needed; `rf_chip_en_o`=1 one edge after release.
- Single request:
  - Stimulus: req 2 valid with addr 0x05, data 0x7F in cycle N.
  - Required response: ready[2] high in N; in N+1 `rf_write_en_n_o`=0, addr 0x05, data 0x7F, `grant_id_o`=2; rf reads 0x7F at addr 5 afterwards.
- Round-robin fairness:
  - Stimulus: all 4 requesters hold valid continuously from reset.
  - Required response: grants 0,1,2,3,0,1 on consecutive cycles, one write per cycle with no bubbles.
- Clear priority and length:
  - Stimulus: fill addr 0..3 with nonzero data; pulse `clear_i` with req 1 valid in the same cycle.
  - Required response: ready[1]=0 that cycle; `busy_o` high for exactly DEPTH cycles; all DEPTH registers read 0 afterwards; req 1 accepted in the first RUN cycle.
- Clear re-trigger ignored:
  - Stimulus: pulse `clear_i` again during CLEAR.
  - Required response: sequence length unchanged at DEPTH cycles.
- Reset mid-clear:
  - Stimulus: assert `rst` when `cnt`=10.
  - Required response: `rf_write_en_n_o`=1 at once; no writes after release until a new request or clear; `busy_o`=0.
